muldiv_sched: RTL

- Sequencer that shares the execute stage's multi-cycle multiplier and divider between MUL*/DIV*/MOD* instructions.
- Accepts one request from execute and drives the selected unit's en/is_signed until done.
- Captures and formats the 32-bit result, and holds it across downstream stall.
- Aborts on pipeline flush; produces the execute-stage stall term.

---
 rtl/muldiv_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/muldiv_sched.sv
// muldiv_sched: shares one multi-cycle multiplier and one divider between MUL*/DIV*/MOD* ops
// Ports: clk, rst_n (async active-low); flush_i aborts, stall_i holds the result in DONE;
//        req_valid/req_op/req_a/req_b request from execute, busy_o is the execute stall term;
//        resp_valid/resp_data formatted result; mul_*/div_* drive and collect the shared units.
// Optional: define MULDIV_DIV_CACHE_EN for a single-entry cache of the last completed divide.
module muldiv_sched #(
    parameter int DATA_W      = 32,
    parameter int CACHE_IDX_W = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                stall_i,
    input  logic                req_valid,
    input  logic [2:0]          req_op,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    output logic                busy_o,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_data,
    output logic                mul_en,
    output logic                mul_signed,
    output logic [DATA_W-1:0]   mul_a,
    output logic [DATA_W-1:0]   mul_b,
    input  logic [2*DATA_W-1:0] mul_out,
    input  logic                mul_done,
    output logic                div_en,
    output logic                div_signed,
    output logic [DATA_W-1:0]   div_a,
    output logic [DATA_W-1:0]   div_b,
    input  logic [DATA_W-1:0]   div_q,
    input  logic [DATA_W-1:0]   div_r,
    input  logic                div_done
);
    typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV, DONE} state_t;

    if (CACHE_IDX_W != 0) begin : g_cfg_err
        $error("muldiv_sched: only a single-entry divide cache is supported (CACHE_IDX_W must be 0)");
    end

    state_t            state, state_d;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] a_q, b_q, res_q, res_d;
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic              take;

    assign take = (state == IDLE) & req_valid & ~flush_i;

`ifdef MULDIV_DIV_CACHE_EN
    logic              c_valid, c_sgn, c_wr;
    logic [DATA_W-1:0] c_a, c_b, c_q, c_r;
    // req_op[1] clear means a signed divide (Q/R)
    assign hit      = c_valid & (req_a == c_a) & (req_b == c_b) & (c_sgn == ~req_op[1]);
    assign hit_data = req_op[0] ? c_r : c_q;
    assign c_wr     = (state == RUN_DIV) & div_done & ~flush_i;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid <= 1'b0;
            c_sgn   <= 1'b0;
            c_a     <= '0;
            c_b     <= '0;
            c_q     <= '0;
            c_r     <= '0;
        end else if (c_wr) begin
            c_valid <= 1'b1;
            c_sgn   <= ~op_q[1];
            c_a     <= a_q;
            c_b     <= b_q;
            c_q     <= div_q;
            c_r     <= div_r;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_comb begin
        state_d = state;
        res_d   = res_q;
        mul_en  = 1'b0;
        div_en  = 1'b0;
        case (state)
            IDLE: if (take) begin
                // reserved op, zero divisor and cache hits finish without touching a unit
                state_d = (req_op == 3'd3 || (req_op[2] && (req_b == '0 || hit))) ? DONE :
                          req_op[2] ? RUN_DIV : RUN_MUL;
                res_d   = (req_op[2] && req_b != '0 && hit) ? hit_data : '0;
            end
            RUN_MUL: begin
                mul_en  = ~mul_done & ~flush_i;
                state_d = flush_i ? IDLE : mul_done ? DONE : RUN_MUL;
                if (!flush_i && mul_done)
                    res_d = (op_q == 2'd0) ? mul_out[DATA_W-1:0] : mul_out[2*DATA_W-1:DATA_W];
            end
            RUN_DIV: begin
                div_en  = ~div_done & ~flush_i;
                state_d = flush_i ? IDLE : div_done ? DONE : RUN_DIV;
                if (!flush_i && div_done)
                    res_d = op_q[0] ? div_r : div_q;
            end
            DONE:    state_d = (flush_i || !stall_i) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            res_q <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_d;
            res_q <= res_d;
            if (take) begin
                op_q <= req_op[1:0];
                a_q  <= req_a;
                b_q  <= req_b;
            end
        end
    end

    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign div_a      = a_q;
    assign div_b      = b_q;
    assign mul_signed = (state == RUN_MUL) & (op_q != 2'd2);
    assign div_signed = (state == RUN_DIV) & ~op_q[1];
    assign resp_valid = (state == DONE);
    assign resp_data  = res_q;
    // gated by rst_n so every output reads 0 while reset is held
    assign busy_o     = rst_n & req_valid & (state != DONE);
endmodule
